fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch front end.
// Walks the PC through an instruction ROM one request at a time and hands
// each fetched word to decode with a valid/ready handshake. Branches either
// redirect the PC directly or squash the request already in flight.
// A halt request is sticky and parks the sequencer until reset.

module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_out,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2,
    HALT = 2'd3
  } fetchState_e;

  fetchState_e state_q;

  logic [31:0] pc_q;
  logic [31:0] instOut_q;
  logic [31:0] instPc_q;
  logic [15:0] fetchCount_q;
  logic        imemReq_q;
  logic        instValid_q;
  logic        halted_q;
  logic        squash_q;
  logic [31:0] squashTarget_q;
  logic        haltPending_q;

  logic [31:0] pcPlusStep_d;
  logic [15:0] countPlusOne_d;
  logic [31:0] redirectTarget_d;
  logic        haltPendingNow;

  // Arithmetic and redirect selection shared by the state machine.
  // A branch arriving in the same cycle as the ack is newer than any
  // target latched earlier, so it takes precedence.
  always_comb begin
    pcPlusStep_d     = pc_q + PC_STEP;
    countPlusOne_d   = fetchCount_q + 16'd1;
    redirectTarget_d = branch_req ? branch_target : squashTarget_q;
    haltPendingNow   = haltPending_q | halt_req;
  end

  // Fetch state machine with all outputs held in registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      pc_q           <= RESET_VECTOR;
      instOut_q      <= 32'd0;
      instPc_q       <= 32'd0;
      fetchCount_q   <= 16'd0;
      imemReq_q      <= 1'b0;
      instValid_q    <= 1'b0;
      halted_q       <= 1'b0;
      squash_q       <= 1'b0;
      squashTarget_q <= 32'd0;
      haltPending_q  <= 1'b0;
    end else begin
      haltPending_q <= haltPendingNow;

      case (state_q)
        IDLE: begin
          if (haltPendingNow) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (branch_req) begin
            pc_q <= branch_target;
          end else if (en) begin
            state_q   <= REQ;
            imemReq_q <= 1'b1;
          end
        end

        REQ: begin
          if (imem_ack) begin
            if (squash_q || branch_req) begin
              pc_q     <= redirectTarget_d;
              squash_q <= 1'b0;
            end else begin
              instOut_q   <= imem_rdata;
              instPc_q    <= pc_q;
              pc_q        <= pcPlusStep_d;
              state_q     <= OUT;
              imemReq_q   <= 1'b0;
              instValid_q <= 1'b1;
            end
          end else if (branch_req) begin
            squash_q       <= 1'b1;
            squashTarget_q <= branch_target;
          end
        end

        OUT: begin
          if (branch_req) begin
            instValid_q <= 1'b0;
            pc_q        <= branch_target;
            state_q     <= REQ;
            imemReq_q   <= 1'b1;
          end else if (inst_ready) begin
            instValid_q  <= 1'b0;
            fetchCount_q <= countPlusOne_d;
            if (haltPendingNow) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else if (en) begin
              state_q   <= REQ;
              imemReq_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        HALT: begin
          imemReq_q   <= 1'b0;
          instValid_q <= 1'b0;
          halted_q    <= 1'b1;
        end

        default: begin
          state_q     <= IDLE;
          imemReq_q   <= 1'b0;
          instValid_q <= 1'b0;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imemReq_q;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign inst_valid  = instValid_q;
  assign inst_out    = instOut_q;
  assign inst_pc     = instPc_q;
  assign halted      = halted_q;
  assign fetch_count = fetchCount_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer.
// A second instance with RESET_VECTOR at the top of the address space
// shares every input with the main instance to exercise PC wrap.

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        branch_req;
  logic [31:0] branch_target;
  logic        halt_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_ready;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] pc_out;
  logic        halted;
  logic [15:0] fetch_count;

  logic        dut2ImemReq;
  logic [31:0] dut2ImemAddr;
  logic        dut2InstValid;
  logic [31:0] dut2InstOut;
  logic [31:0] dut2InstPc;
  logic [31:0] dut2PcOut;
  logic        dut2Halted;
  logic [15:0] dut2FetchCount;

  int compareCount = 0;
  int failCount    = 0;

  fetch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .branch_req   (branch_req),
    .branch_target(branch_target),
    .halt_req     (halt_req),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_out     (inst_out),
    .inst_pc      (inst_pc),
    .pc_out       (pc_out),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  fetch_sequencer #(.RESET_VECTOR(32'hFFFF_FFFF), .PC_STEP(32'd1)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .branch_req   (branch_req),
    .branch_target(branch_target),
    .halt_req     (halt_req),
    .imem_req     (dut2ImemReq),
    .imem_addr    (dut2ImemAddr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (dut2InstValid),
    .inst_ready   (inst_ready),
    .inst_out     (dut2InstOut),
    .inst_pc      (dut2InstPc),
    .pc_out       (dut2PcOut),
    .halted       (dut2Halted),
    .fetch_count  (dut2FetchCount)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Drive every input for the next edge, then step one cycle and settle.
  task automatic applyStimulus(input logic rstV, input logic enV, input logic brV,
                               input logic [31:0] tgtV, input logic haltV,
                               input logic ackV, input logic [31:0] rdataV,
                               input logic readyV);
    rst           = rstV;
    en            = enV;
    branch_req    = brV;
    branch_target = tgtV;
    halt_req      = haltV;
    imem_ack      = ackV;
    imem_rdata    = rdataV;
    inst_ready    = readyV;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    rst = 1'b0; en = 1'b0; branch_req = 1'b0; branch_target = 32'd0;
    halt_req = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;

    // Reset values
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_imem_req", imem_req, 0);
    checkOutput("rst_inst_valid", inst_valid, 0);
    checkOutput("rst_inst_out", inst_out, 0);
    checkOutput("rst_inst_pc", inst_pc, 0);
    checkOutput("rst_pc_out", pc_out, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_fetch_count", fetch_count, 0);
    checkOutput("rst_dut2_pc_out", dut2PcOut, 32'hFFFF_FFFF);

    // Back-to-back fetches with a zero-wait ROM
    $display("[TB] sequential fetch");
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("seq_first_req", imem_req, 1);
    checkOutput("seq_first_addr", imem_addr, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 1, 32'h1000 + i, 1);
      checkOutput("seq_valid", inst_valid, 1);
      checkOutput("seq_inst_pc", inst_pc, i);
      checkOutput("seq_inst_out", inst_out, 32'h1000 + i);
      checkOutput("seq_req_low", imem_req, 0);
      checkOutput("seq_pc_out", pc_out, i + 1);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
      checkOutput("seq_next_req", imem_req, 1);
      checkOutput("seq_next_addr", imem_addr, i + 1);
      checkOutput("seq_valid_low", inst_valid, 0);
      checkOutput("seq_count", fetch_count, i + 1);
    end

    // Dropping en mid-fetch still completes the instruction
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("en0_req_held", imem_req, 1);
    checkOutput("en0_addr_held", imem_addr, 4);
    applyStimulus(1, 0, 0, 0, 0, 1, 32'h2000, 0);
    checkOutput("en0_inst_pc", inst_pc, 4);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("en0_stall_valid", inst_valid, 1);
    checkOutput("en0_stall_out", inst_out, 32'h2000);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("en0_idle_req", imem_req, 0);
    checkOutput("en0_idle_valid", inst_valid, 0);
    checkOutput("en0_count", fetch_count, 5);
    checkOutput("en0_pc_out", pc_out, 5);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_stays", imem_req, 0);

    // Slow ROM: address held for three wait cycles
    $display("[TB] delayed ack");
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("wait_addr", imem_addr, 5);
      checkOutput("wait_req", imem_req, 1);
      checkOutput("wait_valid", inst_valid, 0);
    end
    applyStimulus(1, 1, 0, 0, 0, 1, 32'h3000, 0);
    checkOutput("wait_ack_valid", inst_valid, 1);
    checkOutput("wait_ack_pc", inst_pc, 5);
    checkOutput("wait_ack_out", inst_out, 32'h3000);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
    checkOutput("wait_count", fetch_count, 6);
    checkOutput("wait_next_addr", imem_addr, 6);

    // Branch during an outstanding request squashes the returned data
    $display("[TB] squash");
    applyStimulus(1, 1, 1, 32'h40, 0, 0, 0, 0);
    checkOutput("sq_req_kept", imem_req, 1);
    checkOutput("sq_addr_kept", imem_addr, 6);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("sq_addr_kept2", imem_addr, 6);
    applyStimulus(1, 1, 0, 0, 0, 1, 32'h0BAD, 0);
    checkOutput("sq_no_valid", inst_valid, 0);
    checkOutput("sq_new_req", imem_req, 1);
    checkOutput("sq_new_addr", imem_addr, 32'h40);
    checkOutput("sq_out_unchanged", inst_out, 32'h3000);
    applyStimulus(1, 1, 1, 32'h50, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 32'h60, 0, 1, 32'h0BAD, 0);
    checkOutput("sq_last_wins", imem_addr, 32'h60);
    checkOutput("sq_no_valid2", inst_valid, 0);
    applyStimulus(1, 1, 0, 0, 0, 1, 32'h4444, 0);
    checkOutput("sq_deliver_pc", inst_pc, 32'h60);
    checkOutput("sq_deliver_out", inst_out, 32'h4444);

    // Branch while presenting an instruction drops it
    $display("[TB] branch in OUT");
    applyStimulus(1, 1, 1, 32'h80, 0, 0, 0, 1);
    checkOutput("bo_valid_low", inst_valid, 0);
    checkOutput("bo_count_same", fetch_count, 6);
    checkOutput("bo_req", imem_req, 1);
    checkOutput("bo_addr", imem_addr, 32'h80);

    // Halt requested mid-fetch takes effect after delivery
    $display("[TB] halt");
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 0);
    checkOutput("halt_req_kept", imem_req, 1);
    checkOutput("halt_not_yet", halted, 0);
    applyStimulus(1, 1, 0, 0, 0, 1, 32'h5555, 0);
    checkOutput("halt_deliver_valid", inst_valid, 1);
    checkOutput("halt_deliver_pc", inst_pc, 32'h80);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
    checkOutput("halt_set", halted, 1);
    checkOutput("halt_req_low", imem_req, 0);
    checkOutput("halt_valid_low", inst_valid, 0);
    checkOutput("halt_count", fetch_count, 7);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 1, 32'h99, 0, 1, 0, 1);
      checkOutput("halt_sticky", halted, 1);
      checkOutput("halt_no_req", imem_req, 0);
      checkOutput("halt_pc_frozen", pc_out, 32'h81);
    end

    // PC wrap and reset mid-request
    $display("[TB] wrap and reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r2_halted", halted, 0);
    checkOutput("r2_pc", pc_out, 0);
    checkOutput("r2_count", fetch_count, 0);
    checkOutput("r2_dut2_pc", dut2PcOut, 32'hFFFF_FFFF);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_req", dut2ImemReq, 1);
    checkOutput("wrap_addr", dut2ImemAddr, 32'hFFFF_FFFF);
    applyStimulus(1, 1, 0, 0, 0, 1, 32'h6666, 0);
    checkOutput("wrap_pc_zero", dut2PcOut, 0);
    checkOutput("wrap_inst_pc", dut2InstPc, 32'hFFFF_FFFF);
    checkOutput("wrap_inst_out", dut2InstOut, 32'h6666);
    checkOutput("wrap_dut1_pc", pc_out, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
    checkOutput("wrap_next_addr", dut2ImemAddr, 0);
    checkOutput("wrap_count", dut2FetchCount, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("midrst_req", imem_req, 0);
    checkOutput("midrst_valid", inst_valid, 0);
    checkOutput("midrst_out", inst_out, 0);
    checkOutput("midrst_inst_pc", inst_pc, 0);
    checkOutput("midrst_count", fetch_count, 0);
    checkOutput("midrst_pc", pc_out, 0);
    checkOutput("midrst_halted", halted, 0);
    checkOutput("midrst_dut2_pc", dut2PcOut, 32'hFFFF_FFFF);
    checkOutput("midrst_dut2_req", dut2ImemReq, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 32'h7777, 1);
    checkOutput("late_ack_valid", inst_valid, 0);
    checkOutput("late_ack_out", inst_out, 0);
    checkOutput("late_ack_req", imem_req, 0);
    checkOutput("late_ack_pc", pc_out, 0);

    // Halt outranks en when idle
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 0);
    checkOutput("idle_halt", halted, 1);
    checkOutput("idle_halt_req", imem_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
